uart_byte_tx: RTL and testbench

UART transmitter that serialises one byte per valid/ready handshake onto `uart_txd`: 8N1 framing, LSB first, idle-high line. It is the transmit counterpart of the board's UART receive path and sits between the core logic and the `uart_txd` pin of the top-level design. At the 50 MHz board clock, the default bit period of 5208 clocks gives 9600 baud.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_bit_timer.sv | 27 ++
 rtl/uart_byte_tx.sv | 112 +++++++++++
 tb/tb_uart_byte_tx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and constants for the transmit and receive paths.
package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 5208;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count; restarts on clr.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic res,
    input  logic clr,
    output logic bit_end
);

    localparam int W = $clog2(CLKS_PER_BIT);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        bit_end = cnt_q == W'(CLKS_PER_BIT - 1);
        cnt_d   = (clr || bit_end) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (res) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: valid/ready byte in, 8N1 LSB-first serial out on a registered idle-high line.
// Define UART_TX_PARITY_EN to add an even-parity bit after the data bits.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       res,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uart_txd,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    uart_state_t state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  idx_q, idx_d;
    logic        txd_q, txd_d;
    logic        accept, bit_end;
`ifdef UART_TX_PARITY_EN
    logic        par_q;
`endif

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk     (clk),
        .res     (res),
        .clr     (accept),
        .bit_end (bit_end)
    );

    assign tx_ready = state_q == IDLE;
    assign tx_busy  = state_q != IDLE;
    assign uart_txd = txd_q;

    always_comb begin
        accept  = tx_valid && tx_ready;
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        tx_done = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                state_d = START;
                shift_d = tx_data;
                idx_d   = '0;
            end
            START: if (bit_end) state_d = DATA;
            DATA: if (bit_end) begin
                shift_d = shift_q >> 1;
                idx_d   = idx_q + 3'd1;
                if (idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) state_d = STOP;
`endif
            // idx_q wrapped to 0 leaving DATA, so it now counts stop bits
            STOP: if (bit_end) begin
                idx_d = idx_q + 3'd1;
                if (idx_q == LAST_STOP) begin
                    idx_d   = '0;
                    state_d = IDLE;
                    tx_done = !res;
                end
            end
            default: state_d = IDLE;
        endcase
        // line is registered, so it follows the state being entered
`ifdef UART_TX_PARITY_EN
        txd_d = state_d == START  ? 1'b0 :
                state_d == DATA   ? shift_d[0] :
                state_d == PARITY ? par_q : 1'b1;
`else
        txd_d = state_d == START ? 1'b0 :
                state_d == DATA  ? shift_d[0] : 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            txd_q   <= txd_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (res)         par_q <= 1'b0;
        else if (accept) par_q <= ^tx_data;
    end
`endif

endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx: randomized and directed frame checks against a bit-position line model.
module tb_uart_byte_tx;

    localparam int N  = 16;
    localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = 9 + PAR + SB;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, uart_txd, tx_busy, tx_done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_byte_tx #(.CLKS_PER_BIT(N), .STOP_BITS(SB)) dut (
        .clk      (clk),
        .res      (res),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .uart_txd (uart_txd),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // expected line level for bit slot k of a frame carrying b
    function automatic logic exp_line(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (PAR == 1 && k == 9) return ^b;
        return 1'b1;
    endfunction

    // entered in cycle 1 of a frame; leaves in cycle FRAME*N+1
    task automatic check_frame(input logic [7:0] b, input logic hold, input logic [7:0] nxt,
                               input int chg_at, input int pulse_at);
        logic [7:0] rx = 8'h00;
        for (int c = 1; c <= FRAME * N; c++) begin
            int k = (c - 1) / N;
            checks++;
            if (tx_done !== (c == FRAME * N)) begin
                failures++;
                $display("FAIL done c=%0d got=%b exp=%b", c, tx_done, c == FRAME * N);
            end
            checks++;
            if (tx_busy !== 1'b1 || tx_ready !== 1'b0) begin
                failures++;
                $display("FAIL busy_ready c=%0d got=%b%b exp=10", c, tx_busy, tx_ready);
            end
            if (c % N == N / 2 || c % N == 1 || c % N == 0) begin
                checks++;
                if (uart_txd !== exp_line(b, k)) begin
                    failures++;
                    $display("FAIL line c=%0d slot=%0d got=%b exp=%b", c, k, uart_txd, exp_line(b, k));
                end
                if (c % N == N / 2 && k >= 1 && k <= 8) rx[k-1] = uart_txd;
            end
            if (c == chg_at) tx_data = nxt;
            tx_valid = hold || (c == pulse_at);
            tick();
        end
        checks++;
        if (rx !== b) begin
            failures++;
            $display("FAIL rx_byte got=%h exp=%h", rx, b);
        end
        checks++;
        if (tx_ready !== 1'b1 || uart_txd !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
            failures++;
            $display("FAIL idle_gap got=rdy%b txd%b busy%b done%b exp=rdy1 txd1 busy0 done0",
                     tx_ready, uart_txd, tx_busy, tx_done);
        end
    endtask

    task automatic start_frame(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        checks++;
        if (tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_before_start got=%b exp=1", tx_ready);
        end
        tick();
    endtask

    task automatic test_reset();
        res      = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (uart_txd !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold i=%0d got=txd%b busy%b done%b exp=txd1 busy0 done0",
                         i, uart_txd, tx_busy, tx_done);
            end
        end
        res      = 1'b0;
        tx_valid = 1'b0;
        tick();
        checks++;
        if (tx_ready !== 1'b1 || tx_busy !== 1'b0 || uart_txd !== 1'b1) begin
            failures++;
            $display("FAIL reset_release got=rdy%b busy%b txd%b exp=rdy1 busy0 txd1",
                     tx_ready, tx_busy, uart_txd);
        end
    endtask

    task automatic test_single();
        start_frame(8'hA5);
        check_frame(8'hA5, 1'b0, 8'h00, 0, 0);
    endtask

    task automatic test_back_to_back();
        start_frame(8'h00);
        check_frame(8'h00, 1'b1, 8'hFF, 1, 0);
        tick();
        check_frame(8'hFF, 1'b0, 8'h00, 0, 0);
    endtask

    task automatic test_reset_mid_frame();
        start_frame(8'h3C);
        tx_valid = 1'b0;
        for (int c = 1; c < 4 * N + N / 2; c++) tick();
        checks++;
        if (uart_txd !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_bit3 got=%b exp=1", uart_txd);
        end
        res = 1'b1;
        tick();
        res = 1'b0;
        checks++;
        if (uart_txd !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got=txd%b busy%b done%b exp=txd1 busy0 done0",
                     uart_txd, tx_busy, tx_done);
        end
        for (int c = 0; c < 8 * N; c++) begin
            tick();
            checks++;
            if (tx_done !== 1'b0 || uart_txd !== 1'b1 || tx_ready !== 1'b1) begin
                failures++;
                $display("FAIL post_reset_idle c=%0d got=done%b txd%b rdy%b exp=done0 txd1 rdy1",
                         c, tx_done, uart_txd, tx_ready);
            end
        end
        start_frame(8'h55);
        check_frame(8'h55, 1'b0, 8'h00, 0, 0);
    endtask

    task automatic test_input_stability();
        start_frame(8'hA5);
        check_frame(8'hA5, 1'b0, 8'h00, 5, 50);
        for (int c = 0; c < 2 * N; c++) begin
            tick();
            checks++;
            if (tx_busy !== 1'b0 || uart_txd !== 1'b1) begin
                failures++;
                $display("FAIL spurious_frame c=%0d got=busy%b txd%b exp=busy0 txd1", c, tx_busy, uart_txd);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            logic [7:0] b   = 8'($urandom);
            logic [7:0] nxt = 8'($urandom);
            int idle = $urandom_range(0, 3);
            start_frame(b);
            check_frame(b, 1'b0, nxt, $urandom_range(1, 20), $urandom_range(2, FRAME * N - 1));
            for (int j = 0; j < idle; j++) tick();
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        start_frame(8'hA5);
        check_frame(8'hA5, 1'b0, 8'h00, 0, 0);
        start_frame(8'h01);
        check_frame(8'h01, 1'b0, 8'h00, 0, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid_frame();
        test_input_stability();
        test_random();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
